dump_cntrl: RTL
===============

Name: dump_cntrl

Overview:
- Reads a completed capture out of the circular sample RAM and streams it to the UART transmitter, oldest sample first.
- Started by the command/config block when the host issues a dump command for one channel.
- Sits between cmd_cfg, the per-channel sample RAMs (shared read port via channel mux) and uart_tx.
- Reports busy/done back to cmd_cfg so it can acknowledge the command.

Parameters:
- ENTRIES, 384, samples per channel RAM; the dump length in bytes.
- LOG2, 9, address width, ceil(log2(ENTRIES)).
- NUM_CH, 5, number of channel RAMs selectable.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- dump_start  input  1  one-cycle request from cmd_cfg
- dump_chan  input  3  channel to dump, sampled with dump_start
- cap_waddr  input  LOG2  capture write pointer at capture end (= oldest sample address)
- ren  output  1  RAM read enable, one cycle per byte
- raddr  output  LOG2  RAM read address
- rch  output  3  channel select for RAM read mux (latched)
- rdata  input  8  RAM read data, valid exactly 1 cycle after ren
- tx_data  output  8  byte to uart_tx
- trmt  output  1  one-cycle transmit strobe to uart_tx
- tx_done  input  1  uart_tx byte-complete pulse
- dump_busy  output  1  high from accepted start until done
- dump_done  output  1  one-cycle pulse, dump finished
- dump_err  output  1  one-cycle pulse, start rejected (bad channel)

Behaviour:
- Reset (async, rst_n low): state IDLE, all outputs 0, byte counter 0, raddr 0, rch 0, tx_data 0.
- Start acceptance: in IDLE a dump_start with dump_chan < NUM_CH latches rch <= dump_chan, raddr <= cap_waddr, byte_cnt <= 0, and goes to READ; dump_busy rises the next cycle.
- dump_start with dump_chan >= NUM_CH: dump_err pulses the next cycle, the block stays IDLE, and no RAM or UART activity occurs.
- dump_start while not in IDLE is ignored (no queueing, no error).
- States:
  - IDLE: waits for an accepted start.
  - READ: ren=1 for one cycle at raddr, then -> RDWAIT.
  - RDWAIT: the 1-cycle RAM latency; tx_data <= rdata, then -> SEND.
  - SEND: trmt=1 for one cycle, then -> TXWAIT.
  - TXWAIT: wait for tx_done. On tx_done, byte_cnt+1 and raddr advance. If the new byte_cnt == ENTRIES -> DONE, else -> READ.
  - DONE: dump_done=1 for one cycle, -> IDLE.
- Address wrap: raddr advances as raddr+1, except raddr == ENTRIES-1 -> 0. raddr never reaches ENTRIES..2^LOG2-1.
- The first byte sent is at cap_waddr; the last is at (cap_waddr-1) mod ENTRIES.
- byte_cnt is LOG2+1 bits wide so ENTRIES is representable for any parameter choice. Exactly ENTRIES bytes are sent per dump.
- Per-byte latency: ren to trmt is 2 cycles (READ, RDWAIT, SEND).
- tx_data holds stable from SEND until the next RDWAIT.
- tx_done outside TXWAIT is ignored.
- dump_busy = (state != IDLE); it is low during the single DONE cycle only if registered as in IDLE; it is decided high through DONE and low the cycle after dump_done.
- cap_waddr and dump_chan are only sampled on the accepting cycle; later changes have no effect mid-dump.
- Reset asserted mid-dump aborts immediately to IDLE. No dump_done is issued, and trmt and ren drop the same instant.

Decomposition:
- Shared package cap_pkg holds:
  - the ENTRIES/LOG2 defaults, shared with capture_cntrl;
  - the dump state enum dump_state_t {IDLE, READ, RDWAIT, SEND, TXWAIT, DONE};
  - NUM_CH.
- One sub-module, circ_addr_cnt: a LOG2-bit load/increment counter with wrap at ENTRIES-1. It is reusable by capture_cntrl's waddr logic.

Test Plan:
- Basic dump: ENTRIES=384, cap_waddr=0, chan 2, RAM holds addr[7:0] -> 384 bytes 0x00..0x7F,0x80..0xFF,0x00..0x7F in order; one dump_done; dump_busy high throughout.
- Wrap: cap_waddr=380 -> first bytes come from addresses 380,381,382,383,0,1; last byte from 379; raddr never exceeds 383.
- Bad channel: dump_start with dump_chan=5 -> dump_err pulse after 1 cycle; no ren, no trmt, no dump_busy.
- Ignored restart: second dump_start (chan 0) at byte 10 of a chan-3 dump -> rch stays 3; total remains 384 bytes; one dump_done.
- UART backpressure: tx_done delayed 1000 cycles per byte, plus a stray tx_done during READ -> no extra trmt; each trmt is exactly 2 cycles after its ren.
- Reset mid-dump: rst_n low at byte 100 -> all outputs 0 immediately, no dump_done. A fresh dump_start then sends 384 bytes from the new cap_waddr.

Source files
------------

// File: rtl/cap_pkg.sv
// Shared capture/dump definitions: RAM geometry, channel count and dump FSM states.
package cap_pkg;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
    localparam int NUM_CH  = 5;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RDWAIT,
        SEND,
        TXWAIT,
        DONE
    } dump_state_t;

endpackage

// File: rtl/circ_addr_cnt.sv
// Load/increment address counter for a circular RAM of ENTRIES words.
// Wraps from ENTRIES-1 back to 0, so addresses past the RAM depth never appear.
module circ_addr_cnt
    import cap_pkg::*;
#(
    parameter int ENTRIES_P = ENTRIES,
    parameter int LOG2_P    = LOG2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LOG2_P-1:0] load_val,
    input  logic              inc,
    output logic [LOG2_P-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= (cnt == LOG2_P'(ENTRIES_P - 1)) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dump_cntrl.sv
// Streams one channel's circular capture RAM to the UART, oldest sample first.
// One byte at a time: read, wait out RAM latency, strobe UART, wait for tx_done.
module dump_cntrl
    import cap_pkg::*;
#(
    parameter int ENTRIES_P = ENTRIES,
    parameter int LOG2_P    = LOG2,
    parameter int NUM_CH_P  = NUM_CH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start,
    input  logic [2:0]        dump_chan,
    input  logic [LOG2_P-1:0] cap_waddr,
    output logic              ren,
    output logic [LOG2_P-1:0] raddr,
    output logic [2:0]        rch,
    input  logic [7:0]        rdata,
    output logic [7:0]        tx_data,
    output logic              trmt,
    input  logic              tx_done,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              dump_err
);

    // One extra bit so a count of exactly ENTRIES fits for any depth.
    localparam int CNT_W = LOG2_P + 1;

    dump_state_t      state;
    logic [CNT_W-1:0] byte_cnt;
    logic             chan_ok;
    logic             accept;
    logic             advance;
    logic             last_byte;

    assign chan_ok   = int'(dump_chan) < NUM_CH_P;
    assign accept    = (state == IDLE) && dump_start && chan_ok;
    assign advance   = (state == TXWAIT) && tx_done;
    assign last_byte = (byte_cnt == CNT_W'(ENTRIES_P - 1));

    circ_addr_cnt #(
        .ENTRIES_P (ENTRIES_P),
        .LOG2_P    (LOG2_P)
    ) u_raddr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (cap_waddr),
        .inc      (advance),
        .cnt      (raddr)
    );

    // Outputs are set on the transition into the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            rch       <= '0;
            tx_data   <= '0;
            ren       <= 1'b0;
            trmt      <= 1'b0;
            dump_busy <= 1'b0;
            dump_done <= 1'b0;
            dump_err  <= 1'b0;
        end else begin
            ren       <= 1'b0;
            trmt      <= 1'b0;
            dump_done <= 1'b0;
            dump_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        if (chan_ok) begin
                            rch       <= dump_chan;
                            byte_cnt  <= '0;
                            ren       <= 1'b1;
                            dump_busy <= 1'b1;
                            state     <= READ;
                        end else begin
                            dump_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state <= RDWAIT;
                end
                RDWAIT: begin
                    tx_data <= rdata;
                    trmt    <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    state <= TXWAIT;
                end
                TXWAIT: begin
                    if (tx_done) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (last_byte) begin
                            dump_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            ren   <= 1'b1;
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    dump_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    dump_busy <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
